move_cmd: RTL and testbench
===========================

# move_cmd

Front-end command stage for the cursor position counters. It synchronizes and debounces four raw direction buttons and turns each debounced press into one move command on the downstream counter's `row_en`/`col_en`/`add_n`/`fire` inputs. Select lines are held stable around a single-cycle `fire` pulse, and `fire` is low for at least one cycle between pulses, so the counter's fire-edge detector sees every command exactly once.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable synchronized cycles before the debounced level changes; legal range ≥2.
- `REPEAT_DELAY`, 25000000: hold time before the first auto-repeat; used only with the macro; ≥4.
- `REPEAT_PERIOD`, 5000000: auto-repeat interval; used only with the macro; ≥4.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_up` in 1: raw asynchronous button; row −1.
- `btn_down` in 1: raw asynchronous button; row +1.
- `btn_left` in 1: raw asynchronous button; col −1.
- `btn_right` in 1: raw asynchronous button; col +1.
- `row_en` out 1: command targets the row counter.
- `col_en` out 1: command targets the column counter.
- `add_n` out 1: 0 = increment, 1 = decrement.
- `fire` out 1: single-cycle command strobe.
- `busy` out 1: FSM is not IDLE.

## Operation
- Per button: 2-flop synchronizer, then a debouncer.
- Debouncer counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counter clears whenever the synchronized input equals the debounced level.
  - On reaching DEBOUNCE_CYCLES mismatching cycles, the debounced level flips and the counter clears.
- A rising edge of a debounced level sets that direction's `pending` bit. Falling edges do nothing.
- Pending bits are sticky until serviced.
  - Service priority: up > down > left > right.
  - Re-press of an already-pending direction is absorbed, so at most one queued command per direction.
- FSM states:
  - IDLE: on any pending bit, go to SETUP.
  - SETUP: drive selects for the winner, clear its pending bit, `fire`=0.
  - FIRE: `fire`=1, selects held.
  - GAP: `fire`=0, selects held.
  - After GAP: return to IDLE, or go directly to SETUP if another bit is pending.
- Direction encoding:
  - up: `row_en`=1, `add_n`=1.
  - down: `row_en`=1, `add_n`=0.
  - left: `col_en`=1, `add_n`=1.
  - right: `col_en`=1, `add_n`=0.
  - Exactly one of `row_en`/`col_en` is high outside IDLE.
- In IDLE, `row_en`=`col_en`=0 and `add_n` keeps its last value.
- Opposing buttons pressed together produce two commands in priority order; they are not cancelled.

## Timing
- Reset values: `row_en`=`col_en`=`add_n`=`fire`=`busy`=0. All debounced levels, counters, pending bits and FSM state clear immediately, without waiting for a clock.
- Press latency, raw input stable high and sampled first at edge 1: `fire` is high in the cycle following edge DEBOUNCE_CYCLES+5, when no other command is queued.
- Each command occupies exactly 3 cycles (SETUP, FIRE, GAP). Back-to-back commands give a `fire` period of 3 cycles.
- Selects change only on the SETUP edge.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no command.
- A button held through reset release produces one command after release, because the debounced level restarts at 0.
- `rst_n` asserted during FIRE: `fire` drops asynchronously and the queued commands are lost.

## Configuration
- `MOVE_CMD_REPEAT_EN` defined: auto-repeat enabled.
  - One repeat timer tracks the direction of the last issued command.
  - The timer starts in the cycle after that command's FIRE.
  - While that direction's debounced level stays high, the timer sets its pending bit after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - The timer clears when that debounced level falls or when a different direction is issued.
- `MOVE_CMD_REPEAT_EN` undefined: exactly one command per debounced press. The timer logic and the REPEAT_* parameters are absent.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, `btn_down` rising at edge 1 and held → single `fire` in the cycle after edge 9 with `row_en`=1, `col_en`=0, `add_n`=0. No further `fire` with the macro undefined.
- `btn_right` pulsed high for 3 cycles (DEBOUNCE_CYCLES=4) → no `fire`, `busy` stays 0.
- `btn_up` and `btn_left` rising in the same cycle → `fire` pulses 3 cycles apart: first `row_en`=1/`add_n`=1, then `col_en`=1/`add_n`=1.
- `rst_n` pulsed low during FIRE with `btn_right` pending → `fire`, `busy` and selects go 0 at once. The pending right command is never issued.
- Macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=4, `btn_left` held 30 cycles after its first command → repeat `fire` 8 cycles after the first FIRE, then every 4 cycles. No repeat within 1 debounce window after release.
- Bounce pattern 1-0-1-0-1 (1 cycle each), then steady high → exactly one command.

Source files
------------

// File: rtl/move_cmd_if.sv
// move_cmd_if: the four raw direction buttons and the move command bus that
// drives the cursor position counters (row_en/col_en/add_n/fire) plus busy.
// The command stage uses the master modport; the counter side uses slave.
interface move_cmd_if;
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic row_en;
    logic col_en;
    logic add_n;
    logic fire;
    logic busy;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right,
        output row_en, col_en, add_n, fire, busy
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right,
        input  row_en, col_en, add_n, fire, busy
    );
endinterface

// File: rtl/move_cmd.sv
// move_cmd: synchronizes and debounces four direction buttons and turns each
// debounced press into one SETUP/FIRE/GAP command on the counter inputs.
// Optional auto-repeat of a held button is enabled by defining
// MOVE_CMD_REPEAT_EN (adds the REPEAT_DELAY/REPEAT_PERIOD parameters).
// Direction index: 0 = up, 1 = down, 2 = left, 3 = right (also priority order).
module move_cmd #(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef MOVE_CMD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    move_cmd_if.master bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, FIRE, GAP} state_t;

    logic [3:0]    raw;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [3:0]    level;
    logic [3:0]    level_d;
    logic [3:0]    rise;
    logic [3:0]    pending;
    logic [3:0]    win_hot;
    logic [3:0]    clr;
    logic [3:0]    rep_set;
    logic [DW-1:0] db_cnt [4];
    logic [1:0]    win;
    logic          take;
    logic          row_q;
    logic          col_q;
    logic          add_q;
    state_t        state_q;
    state_t        state_d;

    assign raw  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign rise = level & ~level_d;
    assign clr  = take ? win_hot : 4'b0000;

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 4'b0000;
            sync_b <= 4'b0000;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 4'b0000;
            level_d <= 4'b0000;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            level_d <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Fixed-priority pick among pending directions (up wins)
    always_comb begin
        win     = 2'd0;
        win_hot = 4'b0000;
        if (pending[0]) begin
            win = 2'd0; win_hot = 4'b0001;
        end else if (pending[1]) begin
            win = 2'd1; win_hot = 4'b0010;
        end else if (pending[2]) begin
            win = 2'd2; win_hot = 4'b0100;
        end else if (pending[3]) begin
            win = 2'd3; win_hot = 4'b1000;
        end
    end

    // Sticky pending bits: set by a debounced rise or a repeat, cleared on service
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 4'b0000;
        else        pending <= (pending & ~clr) | rise | rep_set;
    end

    // Command FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Command FSM next state; take marks the edge that enters SETUP
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d = SETUP;
                    take    = 1'b1;
                end
            end
            SETUP: state_d = FIRE;
            FIRE:  state_d = GAP;
            GAP: begin
                if (|pending) begin
                    state_d = SETUP;
                    take    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Selects load on the SETUP edge and drop on return to IDLE; add_n holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 1'b0;
            col_q <= 1'b0;
            add_q <= 1'b0;
        end else if (take) begin
            row_q <= ~win[1];
            col_q <= win[1];
            add_q <= ~win[0];
        end else if (state_q == GAP && state_d == IDLE) begin
            row_q <= 1'b0;
            col_q <= 1'b0;
        end
    end

    assign bus.row_en = row_q;
    assign bus.col_en = col_q;
    assign bus.add_n  = add_q;
    assign bus.fire   = (state_q == FIRE);
    assign bus.busy   = (state_q != IDLE);

`ifdef MOVE_CMD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0]    dir_q;
    logic [1:0]    rep_dir;
    logic [RW-1:0] rep_cnt;
    logic          rep_active;
    logic          rep_start;

    // A new timer run starts after FIRE unless the same held direction is repeating
    assign rep_start = (state_q == FIRE) && (!rep_active || rep_dir != dir_q);

    // Remember the direction of the command currently in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    dir_q <= 2'd0;
        else if (take) dir_q <= win;
    end

    // Request a repeat when the timer expires with the button still held
    always_comb begin
        rep_set = 4'b0000;
        if (rep_active && !rep_start && level[rep_dir] && rep_cnt == '0)
            rep_set[rep_dir] = 1'b1;
    end

    // Repeat timer: REPEAT_DELAY to the first repeat FIRE, then REPEAT_PERIOD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_active <= 1'b0;
            rep_dir    <= 2'd0;
            rep_cnt    <= '0;
        end else if (rep_start) begin
            rep_active <= 1'b1;
            rep_dir    <= dir_q;
            rep_cnt    <= RW'(REPEAT_DELAY - 4);
        end else if (rep_active) begin
            if (!level[rep_dir])
                rep_active <= 1'b0;
            else if (rep_cnt == '0)
                rep_cnt <= RW'(REPEAT_PERIOD - 1);
            else
                rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    assign rep_set = 4'b0000;
`endif

endmodule

// File: tb/tb_move_cmd.sv
// tb_move_cmd: directed and random button stimulus for move_cmd, checked every
// cycle against an edge-numbered reference model of debounce, sticky
// per-direction requests and 3-cycle command slots.
module tb_move_cmd;

    localparam int DEB = 4;
`ifdef MOVE_CMD_REPEAT_EN
    localparam int RDEL = 8;
    localparam int RPER = 4;
`endif

    logic clk = 1'b0;
    logic rst_n;
    move_cmd_if bus ();

    always #5 clk = ~clk;

    move_cmd #(
        .DEBOUNCE_CYCLES(DEB)
`ifdef MOVE_CMD_REPEAT_EN
        , .REPEAT_DELAY(RDEL), .REPEAT_PERIOD(RPER)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int first_fire;
    string test_name;

    // Reference model state (edge n = n-th rising edge since reset release)
    int         n;
    logic [3:0] m_raw [$];
    logic [3:0] m_lvl;
    int         m_run [4];
    logic [3:0] m_rose;
    logic [3:0] m_pend;
    int         m_avail;
    int         m_slot;
    int         m_dir;
    logic       m_add_last;
`ifdef MOVE_CMD_REPEAT_EN
    bit         m_ract;
    int         m_rdir;
    int         m_rnext;
`endif
    logic e_fire, e_busy, e_row, e_col, e_add;

    task automatic modelReset();
        n = 0;
        m_raw.delete();
        m_lvl = 4'b0; m_rose = 4'b0; m_pend = 4'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_avail = 0; m_slot = -10; m_dir = 0; m_add_last = 1'b0;
`ifdef MOVE_CMD_REPEAT_EN
        m_ract = 1'b0; m_rdir = 0; m_rnext = 0;
`endif
        e_fire = 1'b0; e_busy = 1'b0; e_row = 1'b0; e_col = 1'b0; e_add = 1'b0;
    endtask

    task automatic modelStep(input logic [3:0] b);
        logic [3:0] sync;
        logic [3:0] lvl_before;
        int w;
        n++;
        m_raw.push_back(b);
        if (m_raw.size() > 3) void'(m_raw.pop_front());
        sync = (m_raw.size() == 3) ? m_raw[0] : 4'b0;
        lvl_before = m_lvl;
        // a new command slot may open every 3 edges, highest priority first
        if (n >= m_avail && m_pend != 4'b0) begin
            w = 0;
            while (!m_pend[w]) w++;
            m_pend[w] = 1'b0;
            m_slot = n; m_dir = w; m_avail = n + 3;
        end
        m_pend |= m_rose;
`ifdef MOVE_CMD_REPEAT_EN
        if (m_slot >= 1 && n == m_slot + 2 && (!m_ract || m_rdir != m_dir)) begin
            m_ract = 1'b1; m_rdir = m_dir; m_rnext = m_slot + RDEL - 1;
        end else if (m_ract) begin
            if (!lvl_before[m_rdir]) m_ract = 1'b0;
            else if (n == m_rnext) begin
                m_pend[m_rdir] = 1'b1;
                m_rnext += RPER;
            end
        end
`endif
        m_rose = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (sync[i] == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) m_rose[i] = 1'b1;
                end
            end
        end
        if (m_slot >= 1 && n - m_slot <= 2) begin
            e_busy = 1'b1;
            e_fire = (n - m_slot == 1);
            e_row  = (m_dir < 2);
            e_col  = (m_dir >= 2);
            e_add  = (m_dir == 0 || m_dir == 2);
            m_add_last = e_add;
        end else begin
            e_busy = 1'b0; e_fire = 1'b0; e_row = 1'b0; e_col = 1'b0;
            e_add  = m_add_last;
        end
    endtask

    task automatic checkOutput(input string tag);
        if (bus.fire === 1'b1 && first_fire < 0 && n > 0) first_fire = n;
        checks++;
        assert (bus.fire === e_fire) else begin
            failures++;
            $error("[TB] FAIL %s fire: got %b want %b edge %0d", tag, bus.fire, e_fire, n);
        end
        checks++;
        assert (bus.busy === e_busy) else begin
            failures++;
            $error("[TB] FAIL %s busy: got %b want %b edge %0d", tag, bus.busy, e_busy, n);
        end
        checks++;
        assert (bus.row_en === e_row) else begin
            failures++;
            $error("[TB] FAIL %s row_en: got %b want %b edge %0d", tag, bus.row_en, e_row, n);
        end
        checks++;
        assert (bus.col_en === e_col) else begin
            failures++;
            $error("[TB] FAIL %s col_en: got %b want %b edge %0d", tag, bus.col_en, e_col, n);
        end
        checks++;
        assert (bus.add_n === e_add) else begin
            failures++;
            $error("[TB] FAIL %s add_n: got %b want %b edge %0d", tag, bus.add_n, e_add, n);
        end
    endtask

    // Drive buttons (called at a falling edge), step one rising edge, check
    task automatic applyStimulus(input logic [3:0] b);
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = b;
        @(posedge clk);
        modelStep(b);
        #1;
        checkOutput(test_name);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        first_fire = -1;
        checkOutput({test_name, "_reset"});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic holdFor(input logic [3:0] b, input int cycles);
        for (int k = 0; k < cycles; k++) applyStimulus(b);
    endtask

    initial begin
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);

        test_name = "press_down";
        doReset();
        holdFor(4'b0010, 30);
        checks++;
        assert (first_fire === DEB + 5) else begin
            failures++;
            $error("[TB] FAIL latency: first fire edge %0d want %0d", first_fire, DEB + 5);
        end
        holdFor(4'b0000, 12);

        test_name = "glitch_right";
        holdFor(4'b1000, 3);
        holdFor(4'b0000, 12);

        test_name = "up_left";
        holdFor(4'b0101, 20);
        holdFor(4'b0000, 12);

        test_name = "bounce_up";
        applyStimulus(4'b0001); applyStimulus(4'b0000); applyStimulus(4'b0001);
        applyStimulus(4'b0000); applyStimulus(4'b0001);
        holdFor(4'b0001, 15);
        holdFor(4'b0000, 12);

`ifdef MOVE_CMD_REPEAT_EN
        test_name = "repeat_left";
        doReset();
        holdFor(4'b0100, DEB + 5 + 30);
        holdFor(4'b0000, 20);
`endif

        test_name = "reset_in_fire";
        doReset();
        for (int k = 0; k < 40 && !e_fire; k++) applyStimulus(4'b1001);
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0000;
        doReset();
        holdFor(4'b0000, 20);

        test_name = "random";
        for (int seg = 0; seg < 12; seg++)
            holdFor(4'($urandom_range(0, 15)), int'($urandom_range(1, 12)));
        holdFor(4'b0000, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
